// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the hardwired control unit:
//   - 5-bit opcode constants for every instruction the sequencer understands
//   - instruction-register field bit positions (op, Ra, Rb, Rc)
//   - the control FSM state enum
//   - an opcode classifier that groups opcodes by execute sequence
// No ports; imported by control_sequencer.
// ---------------------------------------------------------------------------
package cpu_pkg;

  // Opcode constants
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // Instruction register field positions
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;

  // Control FSM states
  typedef enum logic [3:0] {
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_T6,
    ST_T4N,
    ST_HALT
  } state_t;

  // Execute-sequence families
  typedef enum logic [2:0] {
    CLS_ALU,      // three-register ALU op, LO result only
    CLS_MULDIV,   // three-register op producing HI and LO
    CLS_UNARY,    // neg / not: Ra <= op(Rb)
    CLS_NOP,
    CLS_HALT,
    CLS_ILLEGAL
  } op_class_t;

  function automatic op_class_t classify(input logic [4:0] op);
    op_class_t cls;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL: cls = CLS_ALU;
      OP_DIV, OP_MUL:                          cls = CLS_MULDIV;
      OP_NEG, OP_NOT:                          cls = CLS_UNARY;
      OP_NOP:                                  cls = CLS_NOP;
      OP_HALT:                                 cls = CLS_HALT;
      default:                                 cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/reg_select.sv
// ---------------------------------------------------------------------------
// reg_select
// Combinational 4-to-16 one-hot decoder for general-register enables.
// Ports:
//   sel    in  4  : register index R0..R15
//   en     in  1  : when low the output is all-zero
//   onehot out 16 : bit sel set when en is high, otherwise zero
// ---------------------------------------------------------------------------
module reg_select (
  input  logic [3:0]  sel,
  input  logic        en,
  output logic [15:0] onehot
);

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_dec
      assign onehot[gi] = en & (sel == 4'(gi));
    end
  endgenerate

endmodule

// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
// Hardwired control unit driving every control input of DataPath. Runs the
// three-cycle fetch (T0-T2) and the execute sequence for ALU, neg/not and
// mul/div instructions, plus nop and halt; other opcodes are flagged illegal.
//
// Parameters:
//   MEM_WAIT_MAX : T1 cycles spent waiting for mem_ready before the fetch is
//                  abandoned and illegal is pulsed
// Ports:
//   clock, clear (async, active-low)
//   IR[31:0]     : instruction register contents
//   mem_ready    : memory data valid
//   PCout, Zhighout, Zlowout, MDRout       : bus driver enables
//   MARin, MDRin, IRin, Yin, HIin, LOin,
//   ZHighIn, ZLowIn                        : register load enables
//   IncPC, Read                            : PC increment, memory read
//   opcode[4:0]  : ALU operation select
//   Rin[15:0], Rout[15:0] : one-hot register load / drive enables
//   run          : low once halted
//   illegal      : one-cycle pulse on bad opcode or memory timeout
// ---------------------------------------------------------------------------
module control_sequencer #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        mem_ready,
  output logic        PCout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        HIin,
  output logic        LOin,
  output logic        ZHighIn,
  output logic        ZLowIn,
  output logic        IncPC,
  output logic        Read,
  output logic [4:0]  opcode,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic        run,
  output logic        illegal
);

  import cpu_pkg::*;

  localparam int CNT_W = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  op_class_t  op_class;
  logic       mem_timeout;

  // Decoded (pre-reset-mask) control word
  logic       pcout_dec, zhighout_dec, zlowout_dec, mdrout_dec;
  logic       marin_dec, mdrin_dec, irin_dec, yin_dec;
  logic       hiin_dec, loin_dec, zhighin_dec, zlowin_dec;
  logic       incpc_dec, read_dec, run_dec, illegal_dec;
  logic [4:0] opcode_dec;
  logic       rin_en, rout_en;
  logic [3:0] rin_sel, rout_sel;

  assign op       = IR[OP_MSB:OP_LSB];
  assign ra       = IR[RA_MSB:RA_LSB];
  assign rb       = IR[RB_MSB:RB_LSB];
  assign rc       = IR[RC_MSB:RC_LSB];
  assign op_class = classify(op);

  // Immediate/unused IR bits are not consumed by the control unit.
  logic unused_ir;
  assign unused_ir = ^IR[RC_LSB-1:0];

  assign mem_timeout = (wait_cnt_reg == CNT_W'(MEM_WAIT_MAX));

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_reg    <= ST_T0;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = '0;
    pcout_dec     = 1'b0;
    zhighout_dec  = 1'b0;
    zlowout_dec   = 1'b0;
    mdrout_dec    = 1'b0;
    marin_dec     = 1'b0;
    mdrin_dec     = 1'b0;
    irin_dec      = 1'b0;
    yin_dec       = 1'b0;
    hiin_dec      = 1'b0;
    loin_dec      = 1'b0;
    zhighin_dec   = 1'b0;
    zlowin_dec    = 1'b0;
    incpc_dec     = 1'b0;
    read_dec      = 1'b0;
    run_dec       = 1'b1;
    illegal_dec   = 1'b0;
    opcode_dec    = 5'b00000;
    rin_en        = 1'b0;
    rout_en       = 1'b0;
    rin_sel       = ra;
    rout_sel      = rb;

    case (state_reg)
      ST_T0: begin
        pcout_dec  = 1'b1;
        marin_dec  = 1'b1;
        incpc_dec  = 1'b1;
        state_next = ST_T1;
      end

      ST_T1: begin
        read_dec  = 1'b1;
        mdrin_dec = 1'b1;
        // Data arriving on the last allowed cycle still completes the fetch.
        if (mem_ready) begin
          state_next = ST_T2;
        end else if (mem_timeout) begin
          illegal_dec = 1'b1;
          state_next  = ST_T0;
        end else begin
          wait_cnt_next = wait_cnt_reg + CNT_W'(1);
        end
      end

      ST_T2: begin
        mdrout_dec = 1'b1;
        irin_dec   = 1'b1;
        state_next = ST_T3;
      end

      ST_T3: begin
        case (op_class)
          CLS_ALU, CLS_MULDIV: begin
            rout_en    = 1'b1;
            rout_sel   = rc;
            yin_dec    = 1'b1;
            state_next = ST_T4;
          end
          CLS_UNARY: begin
            rout_en    = 1'b1;
            rout_sel   = rb;
            opcode_dec = op;
            zlowin_dec = 1'b1;
            state_next = ST_T4N;
          end
          CLS_NOP: begin
            state_next = ST_T0;
          end
          CLS_HALT: begin
            state_next = ST_HALT;
          end
          default: begin
            illegal_dec = 1'b1;
            state_next  = ST_T0;
          end
        endcase
      end

      ST_T4: begin
        rout_en     = 1'b1;
        rout_sel    = rb;
        opcode_dec  = op;
        zlowin_dec  = 1'b1;
        zhighin_dec = (op_class == CLS_MULDIV);
        state_next  = ST_T5;
      end

      ST_T5: begin
        zlowout_dec = 1'b1;
        if (op_class == CLS_MULDIV) begin
          loin_dec   = 1'b1;
          state_next = ST_T6;
        end else begin
          rin_en     = 1'b1;
          rin_sel    = ra;
          state_next = ST_T0;
        end
      end

      ST_T6: begin
        zhighout_dec = 1'b1;
        hiin_dec     = 1'b1;
        state_next   = ST_T0;
      end

      ST_T4N: begin
        zlowout_dec = 1'b1;
        rin_en      = 1'b1;
        rin_sel     = ra;
        state_next  = ST_T0;
      end

      ST_HALT: begin
        run_dec    = 1'b0;
        state_next = ST_HALT;
      end

      default: begin
        state_next = ST_T0;
      end
    endcase
  end

  // The state register already sits at T0 during reset, so the decoded T0
  // enables are masked by clear to keep every output quiet until release.
  assign PCout    = pcout_dec    & clear;
  assign Zhighout = zhighout_dec & clear;
  assign Zlowout  = zlowout_dec  & clear;
  assign MDRout   = mdrout_dec   & clear;
  assign MARin    = marin_dec    & clear;
  assign MDRin    = mdrin_dec    & clear;
  assign IRin     = irin_dec     & clear;
  assign Yin      = yin_dec      & clear;
  assign HIin     = hiin_dec     & clear;
  assign LOin     = loin_dec     & clear;
  assign ZHighIn  = zhighin_dec  & clear;
  assign ZLowIn   = zlowin_dec   & clear;
  assign IncPC    = incpc_dec    & clear;
  assign Read     = read_dec     & clear;
  assign illegal  = illegal_dec  & clear;
  assign opcode   = clear ? opcode_dec : 5'b00000;
  assign run      = run_dec | ~clear;

  reg_select u_rin_sel (
    .sel    (rin_sel),
    .en     (rin_en & clear),
    .onehot (Rin)
  );

  reg_select u_rout_sel (
    .sel    (rout_sel),
    .en     (rout_en & clear),
    .onehot (Rout)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// ---------------------------------------------------------------------------
// tb_control_sequencer
// Scoreboard bench: each issued instruction is expanded by a reference model
// into the per-cycle control words it must produce; a monitor pops one word
// per cycle on the falling clock edge and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_control_sequencer;

  localparam int MEM_WAIT_MAX = 15;

  typedef struct packed {
    logic        pcout, zhighout, zlowout, mdrout;
    logic        marin, mdrin, irin, yin, hiin, loin, zhighin, zlowin;
    logic        incpc, read;
    logic [4:0]  opcode;
    logic [15:0] rin, rout;
    logic        run, illegal;
  } ctl_t;

  typedef struct {
    ctl_t  w;
    string tag;
  } exp_t;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] IR = 32'h0;
  logic        mem_ready = 1'b0;

  logic        PCout, Zhighout, Zlowout, MDRout;
  logic        MARin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn;
  logic        IncPC, Read, run, illegal;
  logic [4:0]  opcode;
  logic [15:0] Rin, Rout;

  control_sequencer #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) dut (
    .clock     (clock),
    .clear     (clear),
    .IR        (IR),
    .mem_ready (mem_ready),
    .PCout     (PCout),
    .Zhighout  (Zhighout),
    .Zlowout   (Zlowout),
    .MDRout    (MDRout),
    .MARin     (MARin),
    .MDRin     (MDRin),
    .IRin      (IRin),
    .Yin       (Yin),
    .HIin      (HIin),
    .LOin      (LOin),
    .ZHighIn   (ZHighIn),
    .ZLowIn    (ZLowIn),
    .IncPC     (IncPC),
    .Read      (Read),
    .opcode    (opcode),
    .Rin       (Rin),
    .Rout      (Rout),
    .run       (run),
    .illegal   (illegal)
  );

  always #5 clock = ~clock;

  ctl_t act;
  assign act = {PCout, Zhighout, Zlowout, MDRout,
                MARin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn,
                IncPC, Read, opcode, Rin, Rout, run, illegal};

  exp_t sb_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   n_instr      = 0;

  // Monitor: one control word per cycle, sampled mid-cycle.
  initial begin
    forever begin
      exp_t e;
      @(negedge clock);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        tests_run++;
        if (act !== e.w) begin
          tests_failed++;
          $display("FAIL %s: actual=%h required=%h", e.tag, act, e.w);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic ctl_t idle_word();
    ctl_t w;
    w     = '0;
    w.run = 1'b1;
    return w;
  endfunction

  task automatic push_exp(input ctl_t w, input string tag);
    exp_t e;
    e.w   = w;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  // Issue one instruction: build its expected cycle sequence, queue it, and
  // drive IR/mem_ready for each of those cycles. waits > MEM_WAIT_MAX means
  // memory never answers. rst_t4 drops clear part-way through T4.
  task automatic issue(input logic [31:0] ir, input int waits, input bit rst_t4);
    ctl_t  seq[$];
    string tg[$];
    ctl_t  w;
    int    l, ra, rb, rc;
    bit    tmo, is_alu, is_md, is_un;
    logic [4:0] op;

    op  = ir[31:27];
    ra  = int'(ir[26:23]);
    rb  = int'(ir[22:19]);
    rc  = int'(ir[18:15]);
    tmo = (waits > MEM_WAIT_MAX);
    l   = tmo ? MEM_WAIT_MAX + 1 : waits + 1;
    is_alu = (op inside {[5'd3:5'd11]});
    is_md  = (op == 5'd15) || (op == 5'd16);
    is_un  = (op == 5'd17) || (op == 5'd18);

    w = idle_word(); w.pcout = 1; w.marin = 1; w.incpc = 1;
    seq.push_back(w); tg.push_back("T0");
    for (int k = 0; k < l; k++) begin
      w = idle_word(); w.read = 1; w.mdrin = 1;
      if (tmo && k == l - 1) w.illegal = 1;
      seq.push_back(w); tg.push_back("T1");
    end
    if (!tmo) begin
      w = idle_word(); w.mdrout = 1; w.irin = 1;
      seq.push_back(w); tg.push_back("T2");
      if (is_alu || is_md) begin
        w = idle_word(); w.rout = 16'b1 << rc; w.yin = 1;
        seq.push_back(w); tg.push_back("T3");
        w = idle_word(); w.rout = 16'b1 << rb; w.opcode = op; w.zlowin = 1;
        w.zhighin = is_md;
        seq.push_back(w); tg.push_back("T4");
        w = idle_word(); w.zlowout = 1;
        if (is_md) w.loin = 1; else w.rin = 16'b1 << ra;
        seq.push_back(w); tg.push_back("T5");
        if (is_md) begin
          w = idle_word(); w.zhighout = 1; w.hiin = 1;
          seq.push_back(w); tg.push_back("T6");
        end
      end else if (is_un) begin
        w = idle_word(); w.rout = 16'b1 << rb; w.opcode = op; w.zlowin = 1;
        seq.push_back(w); tg.push_back("T3");
        w = idle_word(); w.zlowout = 1; w.rin = 16'b1 << ra;
        seq.push_back(w); tg.push_back("T4N");
      end else if (op == 5'd26) begin
        seq.push_back(idle_word()); tg.push_back("T3");
      end else if (op == 5'd27) begin
        seq.push_back(idle_word()); tg.push_back("T3");
        for (int k = 0; k < 20; k++) begin
          seq.push_back('0); tg.push_back("HALT");
        end
      end else begin
        w = idle_word(); w.illegal = 1;
        seq.push_back(w); tg.push_back("T3");
      end
    end

    if (rst_t4) begin
      // Keep T0..T3, then two cycles held in reset (the first being T4).
      while (seq.size() > l + 3) begin
        void'(seq.pop_back());
        void'(tg.pop_back());
      end
      seq.push_back(idle_word()); tg.push_back("RST_T4");
      seq.push_back(idle_word()); tg.push_back("RST_HOLD");
    end

    $display("[TB] instr %0d ir=%h op=%b waits=%0d rst=%0d cycles=%0d",
             n_instr, ir, op, waits, rst_t4, seq.size());
    for (int i = 0; i < seq.size(); i++)
      push_exp(seq[i], $sformatf("i%0d c%0d %s", n_instr, i, tg[i]));
    n_instr++;

    for (int i = 0; i < seq.size(); i++) begin
      if (i >= 1 && i <= l) mem_ready = (!tmo && i == l);
      else                  mem_ready = 1'($urandom_range(0, 1));
      // IR is only guaranteed from T3 on; scramble it before that.
      IR = (i >= l + 2) ? ir : $urandom();
      if (rst_t4 && i == l + 3) begin
        #2;
        clear = 1'b0;
      end
      @(posedge clock);
      #1;
    end
    if (rst_t4) clear = 1'b1;
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra,
                                     input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'($urandom)};
  endfunction

  logic [4:0] legal_ops [13] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                                 5'd10, 5'd11, 5'd15, 5'd16, 5'd17, 5'd18};

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0] rop;
    int         rw;

    @(posedge clock);
    #1;
    for (int k = 0; k < 3; k++) begin
      push_exp(idle_word(), $sformatf("reset c%0d", k));
      @(posedge clock);
      #1;
    end
    clear = 1'b1;

    issue(32'h521B8000, 0, 1'b0);                     // shra R4,R3,R7
    issue(32'h80B80000, 0, 1'b0);                     // mul R7,R0
    issue(32'h91180000, 0, 1'b0);                     // not R2,R3
    issue(mk(5'd3, 4'd1, 4'd2, 4'd3), 3, 1'b0);       // add, 3 wait cycles
    issue(mk(5'd4, 4'd15, 4'd0, 4'd9), MEM_WAIT_MAX, 1'b0); // data on last cycle
    issue(mk(5'd5, 4'd5, 4'd6, 4'd7), 99, 1'b0);      // memory timeout
    issue({5'b10111, 27'h0}, 0, 1'b0);                // illegal opcode
    issue(mk(5'd15, 4'd8, 4'd14, 4'd15), 1, 1'b0);    // div
    issue(mk(5'd26, 4'd3, 4'd3, 4'd3), 0, 1'b0);      // nop
    issue(mk(5'd6, 4'd9, 4'd9, 4'd9), 0, 1'b0);       // Ra=Rb=Rc
    issue(mk(5'd17, 4'd0, 4'd0, 4'd12), 2, 1'b0);     // neg Ra=Rb

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 99) < 80) rop = legal_ops[$urandom_range(0, 12)];
      else if ($urandom_range(0, 3) == 0) rop = 5'd26;
      else begin
        rop = 5'($urandom_range(0, 31));
        if (rop == 5'd27) rop = 5'd23;
      end
      rw = ($urandom_range(0, 19) == 0) ? 99 : $urandom_range(0, 3);
      issue(mk(rop, 4'($urandom), 4'($urandom), 4'($urandom)), rw, 1'b0);
    end

    issue(mk(5'd16, 4'd2, 4'd5, 4'd6), 1, 1'b1);      // reset during T4
    issue(mk(5'd7, 4'd11, 4'd12, 4'd13), 0, 1'b0);

    issue(32'hD8000000, 0, 1'b0);                     // halt, held 20 cycles
    clear = 1'b0;
    push_exp(idle_word(), "halt exit reset");
    @(posedge clock);
    #1;
    clear = 1'b1;
    issue(mk(5'd26, 4'd0, 4'd0, 4'd0), 0, 1'b0);      // alive again

    @(posedge clock);
    #1;
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: actual=%0d left required=0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=completion");
    $fatal(1, "watchdog");
  end

endmodule
